// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: board size, switch-to-tile wiring, move FSM states.
package ttt_pkg;

  localparam int unsigned N_TILES    = 9;
  localparam int unsigned TILE_IDX_W = 4;

  // Switch number feeding each tile; each board row is mirrored left-to-right.
  localparam logic [TILE_IDX_W-1:0] TILE_TO_SW [N_TILES] = '{
    4'd2, 4'd1, 4'd0,
    4'd5, 4'd4, 4'd3,
    4'd8, 4'd7, 4'd6
  };

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GUARD
  } move_state_e;

  // Index of the highest set bit; 0 for an empty vector.
  function automatic logic [TILE_IDX_W-1:0] highest_tile(input logic [N_TILES-1:0] v);
    logic [TILE_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned t = 0; t < N_TILES; t++) begin
      if (v[t]) idx = TILE_IDX_W'(t);
    end
    return idx;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// One board switch: 2-FF synchroniser followed by a hold-time debounce counter.
module switch_debounce
  import ttt_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_i,
  output logic stable_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stable_q;
  logic             differ;

  assign differ   = sync_q[1] ^ stable_q;
  assign stable_o = stable_q;

  // Bring the raw switch into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], sw_i};
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (!differ) begin
      cnt_q    <= '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt_q    <= '0;
      stable_q <= ~stable_q;
    end else begin
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/move_input_conditioner.sv
// Turns nine bouncing board switches into one-at-a-time move requests with a valid/ack handshake.
module move_input_conditioner
  import ttt_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_TILES-1:0]    switches,
  input  logic [N_TILES-1:0]    tile_free,
  input  logic                  game_over,
  input  logic                  move_ack,
  output logic                  move_valid,
  output logic [N_TILES-1:0]    move_onehot,
  output logic [TILE_IDX_W-1:0] move_idx,
  output logic                  move_reject,
  output logic [N_TILES-1:0]    stable_sw
);

  logic [N_TILES-1:0]    stable_q;
  logic [N_TILES-1:0]    rise;
  logic [N_TILES-1:0]    rise_t;
  logic [N_TILES-1:0]    pending_q;
  logic [N_TILES-1:0]    pending_d;
  logic [N_TILES-1:0]    sel_onehot;
  logic [N_TILES-1:0]    consumed;
  logic [TILE_IDX_W-1:0] sel_idx;
  move_state_e           state_q;

  // Per-switch synchroniser and debounce.
  for (genvar g = 0; g < N_TILES; g++) begin : g_deb
    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .sw_i     (switches[g]),
      .stable_o (stable_sw[g])
    );
  end

  assign rise = stable_sw & ~stable_q;

  // Reorder switch rises into tile order.
  for (genvar t = 0; t < N_TILES; t++) begin : g_map
    assign rise_t[t] = rise[TILE_TO_SW[t]];
  end

  // Pick the highest pending tile; it is consumed whenever the FSM is idle.
  always_comb begin
    sel_idx    = highest_tile(pending_q);
    sel_onehot = N_TILES'(1) << sel_idx;
    consumed   = '0;
    if (state_q == IDLE && |pending_q) consumed = sel_onehot;
    pending_d  = (pending_q | rise_t) & ~consumed;
  end

  // Edge history and buffered presses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q  <= '0;
      pending_q <= '0;
    end else begin
      stable_q  <= stable_sw;
      pending_q <= pending_d;
    end
  end

  // Move handshake FSM with registered outputs; ack wins over a same-cycle game_over.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      move_valid  <= 1'b0;
      move_onehot <= '0;
      move_idx    <= '0;
      move_reject <= 1'b0;
    end else begin
      move_reject <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|pending_q) begin
            if (!game_over && tile_free[sel_idx]) begin
              state_q     <= ISSUE;
              move_valid  <= 1'b1;
              move_onehot <= sel_onehot;
              move_idx    <= sel_idx;
            end else begin
              move_reject <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (move_ack) begin
            state_q     <= GUARD;
            move_valid  <= 1'b0;
            move_onehot <= '0;
            move_idx    <= '0;
          end else if (game_over) begin
            state_q     <= IDLE;
            move_valid  <= 1'b0;
            move_onehot <= '0;
            move_idx    <= '0;
            move_reject <= 1'b1;
          end
        end
        GUARD: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
